// File: rtl/updown_mod_counter_if.sv
// Bundle of control and status signals for updown_mod_counter.
// The master drives the count controls; the slave (the counter) returns
// the registered count, the terminal-count flag and the wrap/saturate pulse.
interface updown_mod_counter_if #(
  parameter int WIDTH = 4
);
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic             en;
  logic             up;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             ovf;

  modport master (
    output clr, load, load_val, en, up,
    input  q, tc, ovf
  );

  modport slave (
    input  clr, load, load_val, en, up,
    output q, tc, ovf
  );
endinterface

// File: rtl/updown_mod_counter.sv
// Up/down modulo-MODULUS counter with synchronous clear and clamped load.
// Wrap mode rolls over at the ends of the range; saturate mode holds there.
// ovf is a registered one-cycle pulse marking a wrap or a blocked step.
// tc is purely combinational from en/up/q so stages can be cascaded by
// feeding one counter's tc into the next counter's en.
module updown_mod_counter #(
  parameter int              WIDTH    = 4,
  parameter longint unsigned MODULUS  = 16,
  parameter bit              SATURATE = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  updown_mod_counter_if.slave    bus
);

  // Largest legal count; MODULUS may equal 2^WIDTH, so do the subtraction
  // at 64 bits before narrowing.
  localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 64'd1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_next;
  logic             ovf_q;
  logic             ovf_next;
  logic             at_top;
  logic             at_bot;
  logic             terminal;
  logic [WIDTH-1:0] load_clamped;

  // Range-end detection and the terminal condition for the current direction.
  always_comb begin
    at_top   = (count_q == MAX_COUNT);
    at_bot   = (count_q == '0);
    terminal = bus.en & ((bus.up & at_top) | (~bus.up & at_bot));
  end

  // Out-of-range load values are clamped to the top of the count range.
  always_comb begin
    load_clamped = (bus.load_val > MAX_COUNT) ? MAX_COUNT : bus.load_val;
  end

  // Next-state selection with priority clr > load > en > hold.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned; otherwise synthesis infers a latch.
    count_next = count_q;
    ovf_next   = 1'b0;
    if (bus.clr) begin
      count_next = '0;
    end else if (bus.load) begin
      count_next = load_clamped;
    end else if (bus.en) begin
      if (terminal) begin
        ovf_next = 1'b1;
        if (SATURATE) begin
          count_next = count_q;
        end else begin
          count_next = bus.up ? '0 : MAX_COUNT;
        end
      end else begin
        count_next = bus.up ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
      end
    end
  end

  // Count and event-pulse registers, cleared immediately by reset.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    if (!rst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_next;
      ovf_q   <= ovf_next;
    end
  end

  assign bus.q   = count_q;
  assign bus.ovf = ovf_q;
  assign bus.tc  = terminal;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Directed bench for updown_mod_counter: three instances cover wrap mode
// (MODULUS=10), saturate mode (MODULUS=10) and a full binary range
// (MODULUS=16). Expected values are hand-computed constants.
module tb_updown_mod_counter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  updown_mod_counter_if #(.WIDTH(4)) if_a ();
  updown_mod_counter_if #(.WIDTH(4)) if_s ();
  updown_mod_counter_if #(.WIDTH(4)) if_b ();

  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) dut_a (
    .clk(clk), .rst(rst), .bus(if_a.slave)
  );
  updown_mod_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) dut_s (
    .clk(clk), .rst(rst), .bus(if_s.slave)
  );
  updown_mod_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) dut_b (
    .clk(clk), .rst(rst), .bus(if_b.slave)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    if_a.clr = 0; if_a.load = 0; if_a.load_val = '0; if_a.en = 0; if_a.up = 0;
    if_s.clr = 0; if_s.load = 0; if_s.load_val = '0; if_s.en = 0; if_s.up = 0;
    if_b.clr = 0; if_b.load = 0; if_b.load_val = '0; if_b.en = 0; if_b.up = 0;

    // Reset state, asserted from time zero.
    #3;
    check("rst_a_q", 32'(if_a.q), 0);
    check("rst_a_ovf", 32'(if_a.ovf), 0);
    check("rst_s_q", 32'(if_s.q), 0);
    check("rst_b_q", 32'(if_b.q), 0);
    step();
    step();
    rst = 1'b1;
    #2;
    check("rst_release_q", 32'(if_a.q), 0);

    // Wrap-mode up count through 9 -> 0.
    if_a.en = 1; if_a.up = 1;
    check("up_tc_at0", 32'(if_a.tc), 0);
    for (int i = 1; i <= 12; i++) begin
      step();
      check($sformatf("up_q_%0d", i), 32'(if_a.q), 32'(i % 10));
      check($sformatf("up_ovf_%0d", i), 32'(if_a.ovf), (i == 10) ? 1 : 0);
      check($sformatf("up_tc_%0d", i), 32'(if_a.tc), (i % 10 == 9) ? 1 : 0);
    end

    // Clear, then wrap downward 0 -> 9 -> 8.
    if_a.en = 0; if_a.clr = 1;
    step();
    check("clr_q", 32'(if_a.q), 0);
    check("clr_ovf", 32'(if_a.ovf), 0);
    if_a.clr = 0; if_a.en = 1; if_a.up = 0;
    #1;
    check("down_tc_at0", 32'(if_a.tc), 1);
    step();
    check("down_wrap_q", 32'(if_a.q), 9);
    check("down_wrap_ovf", 32'(if_a.ovf), 1);
    step();
    check("down_q8", 32'(if_a.q), 8);
    check("down_ovf_clear", 32'(if_a.ovf), 0);
    if_a.en = 0;
    step();
    check("hold_q", 32'(if_a.q), 8);
    check("hold_ovf", 32'(if_a.ovf), 0);
    check("hold_tc", 32'(if_a.tc), 0);

    // Load clamp and priority.
    if_a.load = 1; if_a.load_val = 4'd15;
    step();
    check("load_clamp", 32'(if_a.q), 9);
    if_a.load_val = 4'd3; if_a.en = 1; if_a.up = 1;
    step();
    check("load_over_en", 32'(if_a.q), 3);
    check("load_ovf", 32'(if_a.ovf), 0);
    if_a.clr = 1; if_a.load_val = 4'd5;
    step();
    check("clr_over_load", 32'(if_a.q), 0);
    if_a.up = 0;
    #1;
    check("tc_ignores_clr", 32'(if_a.tc), 1);
    if_a.clr = 0; if_a.load = 0; if_a.en = 0;

    // Saturate mode: load 7, count up into the ceiling.
    if_s.load = 1; if_s.load_val = 4'd7;
    step();
    check("sat_load", 32'(if_s.q), 7);
    if_s.load = 0; if_s.en = 1; if_s.up = 1;
    step(); check("sat_q1", 32'(if_s.q), 8); check("sat_ovf1", 32'(if_s.ovf), 0);
    step(); check("sat_q2", 32'(if_s.q), 9); check("sat_ovf2", 32'(if_s.ovf), 0);
    step(); check("sat_q3", 32'(if_s.q), 9); check("sat_ovf3", 32'(if_s.ovf), 1);
    step(); check("sat_q4", 32'(if_s.q), 9); check("sat_ovf4", 32'(if_s.ovf), 1);
    step(); check("sat_q5", 32'(if_s.q), 9); check("sat_ovf5", 32'(if_s.ovf), 1);
    if_s.en = 0;
    step();
    check("sat_hold_q", 32'(if_s.q), 9);
    check("sat_hold_ovf", 32'(if_s.ovf), 0);
    if_s.clr = 1;
    step();
    if_s.clr = 0; if_s.en = 1; if_s.up = 0;
    step();
    check("sat_floor_q", 32'(if_s.q), 0);
    check("sat_floor_ovf", 32'(if_s.ovf), 1);
    if_s.en = 0;

    // Full binary range: 15 -> 0, then direction change at q=5.
    if_b.load = 1; if_b.load_val = 4'd15;
    step();
    check("bin_load", 32'(if_b.q), 15);
    if_b.load = 0; if_b.en = 1; if_b.up = 1;
    step();
    check("bin_wrap_q", 32'(if_b.q), 0);
    check("bin_wrap_ovf", 32'(if_b.ovf), 1);
    for (int i = 0; i < 5; i++) step();
    check("bin_q5", 32'(if_b.q), 5);
    check("bin_ovf_q5", 32'(if_b.ovf), 0);
    if_b.up = 0;
    step();
    check("bin_turn_q", 32'(if_b.q), 4);
    if_b.up = 1;
    step();
    check("bin_turn_back", 32'(if_b.q), 5);
    if_b.en = 0;

    // Async reset between edges, held across enabled edges.
    if_a.load = 1; if_a.load_val = 4'd6;
    step();
    check("pre_rst_q", 32'(if_a.q), 6);
    if_a.load = 0; if_a.en = 1; if_a.up = 1;
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_q", 32'(if_a.q), 0);
    check("async_rst_b", 32'(if_b.q), 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("rst_hold_q_%0d", i), 32'(if_a.q), 0);
    end
    rst = 1'b1;

    // Reset coincident with a wrap edge leaves no pending ovf.
    if_a.en = 0; if_a.load = 1; if_a.load_val = 4'd9;
    step();
    check("pre_wrap_q", 32'(if_a.q), 9);
    if_a.load = 0; if_a.en = 1; if_a.up = 1;
    @(posedge clk);
    rst = 1'b0;
    #1;
    check("rst_wrap_q", 32'(if_a.q), 0);
    check("rst_wrap_ovf", 32'(if_a.ovf), 0);
    step();
    check("rst_wrap_ovf_next", 32'(if_a.ovf), 0);
    rst = 1'b1;
    #1;
    check("deassert_no_change", 32'(if_a.q), 0);
    step();
    check("first_edge_after_rst", 32'(if_a.q), 1);
    check("first_edge_ovf", 32'(if_a.ovf), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/updown_mod_counter.md
UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

Interface
REQ-001 Parameter WIDTH, default 4: counter register width in bits, legal range 2..32.
REQ-002 Parameter MODULUS, default 16: count range is 0..MODULUS-1, legal range 2..2^WIDTH.
REQ-003 Parameter SATURATE, default 0: 0 selects wrap mode; 1 selects saturate mode.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset; 0 resets the block immediately, independent of clk.
REQ-006 clr  input  1  synchronous clear, active-high.
REQ-007 load  input  1  synchronous parallel load, active-high.
REQ-008 load_val  input  WIDTH  value captured on load.
REQ-009 en  input  1  count enable, active-high.
REQ-010 up  input  1  direction: 1 counts up, 0 counts down.
REQ-011 q  output  WIDTH  registered count value.
REQ-012 tc  output  1  combinational terminal-count flag.
REQ-013 ovf  output  1  registered one-cycle wrap or saturate event pulse.

Function
REQ-014 q SHALL update only on a rising clk edge while rst=1.
REQ-015 Per edge, priority SHALL be clr > load > en > hold.
REQ-016 clr=1 SHALL set q=0 and ovf=0.
REQ-017 load=1 with clr=0 SHALL set q=load_val when load_val<=MODULUS-1, and q=MODULUS-1 otherwise (clamp); ovf=0.
REQ-018 en=1, up=1, q<MODULUS-1 SHALL set q=q+1; en=1, up=0, q>0 SHALL set q=q-1.
REQ-019 Wrap mode, en=1, up=1, q=MODULUS-1 SHALL set q=0 and ovf=1 in the following cycle.
REQ-020 Wrap mode, en=1, up=0, q=0 SHALL set q=MODULUS-1 and ovf=1 in the following cycle.
REQ-021 Saturate mode, en=1 at the terminal value for the current direction SHALL hold q and set ovf=1 in the following cycle.
REQ-022 Saturate-mode ovf SHALL repeat every cycle that en remains 1 at the terminal value.
REQ-023 en=0 with clr=0 and load=0 SHALL hold q and set ovf=0.
REQ-024 ovf SHALL be 1 only in the cycle immediately after a REQ-019/020/021 event, and 0 otherwise.
REQ-025 tc SHALL equal en & ((up & q==MODULUS-1) | (~up & q==0)).
REQ-026 tc SHALL NOT depend on clr or load, so cascaded counters can chain tc into the next stage's en.
REQ-027 Arithmetic SHALL be modulo MODULUS only; q SHALL never exceed MODULUS-1 in any state reachable from reset.
REQ-028 A direction change SHALL take effect on the same edge that samples the new up value, with no turnaround cycle.
REQ-029 When MODULUS=2^WIDTH, behaviour SHALL be identical to a plain WIDTH-bit binary counter, with no extra comparator latency.

Reset
REQ-030 rst=0 SHALL force q=0 and ovf=0 asynchronously, within the same time step, with no clk edge required.
REQ-031 While rst=0, clk edges and all other inputs SHALL be ignored.
REQ-032 Reset deassertion (0->1) SHALL not change state by itself; the first update occurs on the first rising edge with rst=1.
REQ-033 rst asserted mid-count, coincident with a wrap event, SHALL leave q=0 and ovf=0; no pending ovf survives reset.

Verification
REQ-034 WIDTH=4, MODULUS=10, wrap mode; rst pulse, then en=1, up=1 for 12 edges -> q sequence 1..9,0,1,2; ovf=1 exactly in the cycle after q 9->0; tc=1 only while q=9.
REQ-035 WIDTH=4, MODULUS=10, wrap mode; q=0, en=1, up=0 -> q=9, ovf=1 next cycle; a further edge -> q=8, ovf=0.
REQ-036 SATURATE=1, MODULUS=10; load load_val=7, then en=1, up=1 for 5 edges -> q 8,9,9,9,9; ovf=1 on each cycle after a blocked increment.
REQ-037 Load clamp and priority: load_val=15 with MODULUS=10 -> q=9; clr=1, load=1, en=1 together -> q=0.
REQ-038 Async reset: q=6, drive rst=0 between clk edges -> q=0 immediately, with no clk edge; hold rst=0 across 3 edges with en=1 -> q stays 0.
REQ-039 MODULUS=16, WIDTH=4, en=1, up=1 from q=15 -> q=0, ovf=1; toggle up on the same edge q=5 is sampled -> next q=4.
